cavlc_nc_scheduler: RTL and testbench

Per-macroblock sequencer for the CAVLC residual decoder. Steps through the 16 luma 4x4 blocks in z-scan order and derives nC for each block from the TotalCoeff of the left (nA) and top (nB) neighbours. It pulses the decoder Enable once per block and records each decoded TotalCoeff. Neighbour history is kept in a left-column register set and a top-row line buffer indexed by macroblock column.

---
 rtl/cavlc_pkg.sv | 41 ++++
 rtl/cavlc_nc_scheduler_chk.sv | 27 ++
 rtl/cavlc_tc_linebuf.sv | 43 ++++
 rtl/cavlc_nc_scheduler.sv | 267 ++++++++++++++++++++++++++
 tb/tb_cavlc_nc_scheduler.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// cavlc_pkg: shared types, widths and helpers for the CAVLC residual decoder
// front end.
//   TC_W / NC_W   : width of a stored TotalCoeff value and of a derived nC.
//   sched_state_t : per-macroblock sequencer states.
//   blk_x/blk_y   : split a z-scan 4x4 block index into 2-bit x/y coordinates.
//   blk_idx       : inverse of blk_x/blk_y (coordinates back to z-scan index).
//   nc_avg        : rounded average of two neighbour TotalCoeff values.
package cavlc_pkg;

  localparam int TC_W = 5;
  localparam int NC_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    RUN   = 3'd3,
    SKIP  = 3'd4,
    DONE  = 3'd5
  } sched_state_t;

  function automatic logic [1:0] blk_x(input logic [3:0] idx);
    return {idx[2], idx[0]};
  endfunction

  function automatic logic [1:0] blk_y(input logic [3:0] idx);
    return {idx[3], idx[1]};
  endfunction

  function automatic logic [3:0] blk_idx(input logic [1:0] x, input logic [1:0] y);
    return {y[1], x[1], y[0], x[0]};
  endfunction

  // Sum is taken at 6 bits so 31+31+1 cannot wrap; the halved result always fits NC_W.
  function automatic logic [NC_W-1:0] nc_avg(input logic [TC_W-1:0] a, input logic [TC_W-1:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 6'd1;
    return sum[5:1];
  endfunction

endpackage

// File: rtl/cavlc_nc_scheduler_chk.sv
// cavlc_nc_scheduler_chk: simulation-time checks for cavlc_nc_scheduler.
// Ports:
//   clk    : clock
//   rst_n  : active-low reset (checks idle while asserted)
//   accept : a macroblock request is being accepted this cycle
//   mbx    : macroblock column presented with the request
module cavlc_nc_scheduler_chk #(
  parameter int MAX_MB_WIDTH = 120,
  parameter int MBX_W        = $clog2(MAX_MB_WIDTH)
) (
  input logic             clk,
  input logic             rst_n,
  input logic             accept,
  input logic [MBX_W-1:0] mbx
);

  localparam logic [MBX_W:0] MAX_W = (MBX_W + 1)'(MAX_MB_WIDTH);

  // A column beyond the line buffer would alias other columns' history.
  always @(posedge clk) begin
    if (rst_n && accept) begin
      assert ({1'b0, mbx} < MAX_W)
        else $error("cavlc_nc_scheduler: MbX %0d out of range", mbx);
    end
  end

endmodule

// File: rtl/cavlc_tc_linebuf.sv
// cavlc_tc_linebuf: top-row TotalCoeff line buffer, one entry per 4x4 column
// of the picture (4 entries per macroblock column).
// Ports:
//   clk      : clock
//   rd_en    : read strobe; rd_data is valid the cycle after
//   rd_addr  : read address
//   rd_data  : registered read data
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
// Contents are deliberately not reset; the consumer qualifies them with its
// own availability flag.
module cavlc_tc_linebuf
  import cavlc_pkg::*;
#(
  parameter int DEPTH = 480,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [TC_W-1:0] rd_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [TC_W-1:0] wr_data
);

  logic [TC_W-1:0] mem [0:DEPTH-1];
  logic [TC_W-1:0] rd_data_q;

  // Single write port plus registered single read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cavlc_nc_scheduler.sv
// cavlc_nc_scheduler: per-macroblock sequencer for the CAVLC residual decoder.
// Walks the 16 luma 4x4 blocks in z-scan order, derives nC for each block from
// the left (nA) and top (nB) neighbour TotalCoeff, enables the decoder once
// per block and records the returned TotalCoeff.
// Ports:
//   Clk, nReset        : clock, asynchronous active-low reset
//   MbStart            : one-cycle macroblock request, honoured only when idle
//   MbX                : macroblock column (latched on accept)
//   MbAvailLeft/Top    : neighbour macroblock availability (latched on accept)
//   CodedBlockPattern  : luma CBP, one bit per 8x8 (latched on accept)
//   MbBusy             : high from accept through the MbDone cycle
//   DecEnable          : decoder enable, high for the whole RUN state
//   nC, BlkIdx         : nC and z-scan index of the current block
//   BlockDone          : decoder finished the block, honoured only in RUN
//   TotalCoeff         : decoder TotalCoeff, sampled with BlockDone
//   MbDone             : one-cycle pulse after block 15 completes
// Build option: CAVLC_CBP_SKIP_EN -- when defined, blocks whose 8x8 CBP bit is
// clear are skipped (TotalCoeff recorded as 0, no DecEnable). Otherwise
// CodedBlockPattern is ignored.
module cavlc_nc_scheduler
  import cavlc_pkg::*;
#(
  parameter int MAX_MB_WIDTH = 120,
  parameter int MBX_W        = $clog2(MAX_MB_WIDTH)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             MbStart,
  input  logic [MBX_W-1:0] MbX,
  input  logic             MbAvailLeft,
  input  logic             MbAvailTop,
  input  logic [3:0]       CodedBlockPattern,
  output logic             MbBusy,
  output logic             DecEnable,
  output logic [NC_W-1:0]  nC,
  output logic [3:0]       BlkIdx,
  input  logic             BlockDone,
  input  logic [TC_W-1:0]  TotalCoeff,
  output logic             MbDone
);

  localparam int LB_DEPTH = 4 * MAX_MB_WIDTH;
  localparam int LB_AW    = $clog2(LB_DEPTH);

  sched_state_t     state_q, state_d;
  logic [3:0]       blk_idx_q, blk_idx_d;
  logic [MBX_W-1:0] mbx_q, mbx_d;
  logic             avail_left_q, avail_left_d;
  logic             avail_top_q, avail_top_d;
  logic [NC_W-1:0]  nc_q, nc_d;
  logic             dec_en_q, dec_en_d;
  logic             busy_q, busy_d;
  logic             mb_done_q, mb_done_d;
  logic [TC_W-1:0]  cur_tc_q [16];
  logic [TC_W-1:0]  cur_tc_d [16];
  logic [TC_W-1:0]  left_tc_q [4];
  logic [TC_W-1:0]  left_tc_d [4];

  logic [1:0]       x_s, y_s;
  logic [TC_W-1:0]  na_s, nb_s;
  logic             na_vld_s, nb_vld_s;
  logic [NC_W-1:0]  nc_calc_s;
  logic             blk_wr_s;
  logic [TC_W-1:0]  wr_tc_s;
  logic [TC_W-1:0]  lb_rd_data_s;
  logic [LB_AW-1:0] lb_addr_s;
  logic             accept_s;

`ifdef CAVLC_CBP_SKIP_EN
  logic [3:0]       cbp_q, cbp_d;
`else
  logic             unused_cbp_s;
  assign unused_cbp_s = ^CodedBlockPattern;
`endif

  assign x_s       = blk_x(blk_idx_q);
  assign y_s       = blk_y(blk_idx_q);
  assign accept_s  = (state_q == IDLE) && MbStart;
  // Same address serves the top-row read (y=0) and the bottom-row write (y=3).
  assign lb_addr_s = LB_AW'({mbx_q, x_s});

  cavlc_tc_linebuf #(
    .DEPTH (LB_DEPTH),
    .AW    (LB_AW)
  ) u_linebuf (
    .clk     (Clk),
    .rd_en   (state_q == FETCH),
    .rd_addr (lb_addr_s),
    .rd_data (lb_rd_data_s),
    .wr_en   (blk_wr_s && (y_s == 2'd3)),
    .wr_addr (lb_addr_s),
    .wr_data (wr_tc_s)
  );

  cavlc_nc_scheduler_chk #(
    .MAX_MB_WIDTH (MAX_MB_WIDTH),
    .MBX_W        (MBX_W)
  ) u_chk (
    .clk    (Clk),
    .rst_n  (nReset),
    .accept (accept_s),
    .mbx    (MbX)
  );

  // Neighbour selection and nC derivation for the current block.
  always_comb begin
    na_s      = '0;
    na_vld_s  = 1'b0;
    nb_s      = '0;
    nb_vld_s  = 1'b0;
    nc_calc_s = '0;
    if (x_s != 2'd0) begin
      na_s     = cur_tc_q[blk_idx(x_s - 2'd1, y_s)];
      na_vld_s = 1'b1;
    end else begin
      na_s     = left_tc_q[y_s];
      na_vld_s = avail_left_q;
    end
    if (y_s != 2'd0) begin
      nb_s     = cur_tc_q[blk_idx(x_s, y_s - 2'd1)];
      nb_vld_s = 1'b1;
    end else begin
      nb_s     = lb_rd_data_s;
      nb_vld_s = avail_top_q;
    end
    if (na_vld_s && nb_vld_s) begin
      nc_calc_s = nc_avg(na_s, nb_s);
    end else if (na_vld_s) begin
      nc_calc_s = na_s;
    end else if (nb_vld_s) begin
      nc_calc_s = nb_s;
    end else begin
      nc_calc_s = '0;
    end
  end

  // Sequencer next-state, block bookkeeping and registered-output decode.
  always_comb begin
    state_d      = state_q;
    blk_idx_d    = blk_idx_q;
    mbx_d        = mbx_q;
    avail_left_d = avail_left_q;
    avail_top_d  = avail_top_q;
    nc_d         = nc_q;
    blk_wr_s     = 1'b0;
    wr_tc_s      = TotalCoeff;
`ifdef CAVLC_CBP_SKIP_EN
    cbp_d        = cbp_q;
`endif
    case (state_q)
      IDLE: begin
        if (MbStart) begin
          mbx_d        = MbX;
          avail_left_d = MbAvailLeft;
          avail_top_d  = MbAvailTop;
`ifdef CAVLC_CBP_SKIP_EN
          cbp_d        = CodedBlockPattern;
`endif
          blk_idx_d    = 4'd0;
          state_d      = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        state_d = CALC;
      end
      CALC: begin
        nc_d = nc_calc_s;
`ifdef CAVLC_CBP_SKIP_EN
        if (cbp_q[{y_s[1], x_s[1]}] == 1'b0) begin
          state_d = SKIP;
        end else begin
          state_d = RUN;
        end
`else
        state_d = RUN;
`endif
      end
      RUN, SKIP: begin
        if ((state_q == SKIP) || BlockDone) begin
          blk_wr_s = 1'b1;
          wr_tc_s  = (state_q == SKIP) ? {TC_W{1'b0}} : TotalCoeff;
          if (blk_idx_q == 4'd15) begin
            state_d = DONE;
          end else begin
            blk_idx_d = blk_idx_q + 4'd1;
            state_d   = FETCH;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    dec_en_d  = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    mb_done_d = (state_d == DONE);
  end

  // Current-MB TotalCoeff array and right-column (left-neighbour) registers.
  always_comb begin
    cur_tc_d  = cur_tc_q;
    left_tc_d = left_tc_q;
    if (blk_wr_s) begin
      cur_tc_d[blk_idx_q] = wr_tc_s;
      if (x_s == 2'd3) begin
        left_tc_d[y_s] = wr_tc_s;
      end else begin
        left_tc_d[y_s] = left_tc_q[y_s];
      end
    end else begin
      cur_tc_d = cur_tc_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      blk_idx_q    <= 4'd0;
      mbx_q        <= '0;
      avail_left_q <= 1'b0;
      avail_top_q  <= 1'b0;
      nc_q         <= '0;
      dec_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      mb_done_q    <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cur_tc_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        left_tc_q[i] <= '0;
      end
`ifdef CAVLC_CBP_SKIP_EN
      cbp_q        <= 4'd0;
`endif
    end else begin
      state_q      <= state_d;
      blk_idx_q    <= blk_idx_d;
      mbx_q        <= mbx_d;
      avail_left_q <= avail_left_d;
      avail_top_q  <= avail_top_d;
      nc_q         <= nc_d;
      dec_en_q     <= dec_en_d;
      busy_q       <= busy_d;
      mb_done_q    <= mb_done_d;
      cur_tc_q     <= cur_tc_d;
      left_tc_q    <= left_tc_d;
`ifdef CAVLC_CBP_SKIP_EN
      cbp_q        <= cbp_d;
`endif
    end
  end

  assign MbBusy    = busy_q;
  assign DecEnable = dec_en_q;
  assign nC        = nc_q;
  assign BlkIdx    = blk_idx_q;
  assign MbDone    = mb_done_q;

endmodule

// File: tb/tb_cavlc_nc_scheduler.sv
// tb_cavlc_nc_scheduler: directed and randomized bench for cavlc_nc_scheduler.
// A neighbour-history model indexed by (x,y) block coordinates predicts nC
// for every block; handshake latencies are checked against fixed cycle counts.
module tb_cavlc_nc_scheduler;

  logic       Clk = 1'b0;
  logic       nReset;
  logic       MbStart;
  logic [6:0] MbX;
  logic       MbAvailLeft;
  logic       MbAvailTop;
  logic [3:0] CodedBlockPattern;
  logic       MbBusy;
  logic       DecEnable;
  logic [4:0] nC;
  logic [3:0] BlkIdx;
  logic       BlockDone;
  logic [4:0] TotalCoeff;
  logic       MbDone;

  int checks   = 0;
  int failures = 0;

  int m_cur [4][4];
  int m_left [4];
  int m_lb [480];
  bit m_lbv [480];
  int tc_in [16];
  int exp_fix [16];

  cavlc_nc_scheduler #(.MAX_MB_WIDTH(120), .MBX_W(7)) dut (
    .Clk               (Clk),
    .nReset            (nReset),
    .MbStart           (MbStart),
    .MbX               (MbX),
    .MbAvailLeft       (MbAvailLeft),
    .MbAvailTop        (MbAvailTop),
    .CodedBlockPattern (CodedBlockPattern),
    .MbBusy            (MbBusy),
    .DecEnable         (DecEnable),
    .nC                (nC),
    .BlkIdx            (BlkIdx),
    .BlockDone         (BlockDone),
    .TotalCoeff        (TotalCoeff),
    .MbDone            (MbDone)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bx(input int b);
    return ((b >> 2) & 1) * 2 + (b & 1);
  endfunction

  function automatic int by(input int b);
    return ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
  endfunction

  function automatic int model_nc(input int b, input int mbx, input bit al, input bit at);
    int x, y, na, nb;
    bit va, vb;
    x = bx(b);
    y = by(b);
    if (x > 0) begin na = m_cur[x-1][y]; va = 1'b1; end
    else begin na = m_left[y]; va = al; end
    if (y > 0) begin nb = m_cur[x][y-1]; vb = 1'b1; end
    else begin nb = m_lb[mbx*4 + x]; vb = at; end
    if (va && vb) return (na + nb + 1) / 2;
    if (va) return na;
    if (vb) return nb;
    return 0;
  endfunction

  task automatic clear_tc();
    for (int i = 0; i < 16; i++) begin
      tc_in[i]   = 0;
      exp_fix[i] = -1;
    end
  endtask

  task automatic run_mb(input int mbx, input bit al, input bit at, input int rst_blk, input int spur_blk);
    int n, hold, exp_nc;
    MbX = 7'(mbx); MbAvailLeft = al; MbAvailTop = at; MbStart = 1'b1;
    step();
    MbStart = 1'b0;
    chk("busy_on_accept", MbBusy, 1);
    n = 1;
    for (int b = 0; b < 16; b++) begin
      while (DecEnable !== 1'b1 && n < 8) begin step(); n++; end
      chk("en_latency", n, 3);
      chk("blk_idx", BlkIdx, b);
      exp_nc = model_nc(b, mbx, al, at);
      chk("nc", nC, exp_nc);
      if (exp_fix[b] >= 0) chk("nc_fixed", nC, exp_fix[b]);
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        if (h == 0 && b == spur_blk) begin
          MbStart = 1'b1; MbX = 7'((mbx + 1) % 120); MbAvailLeft = ~al;
        end
        step();
        MbStart = 1'b0;
      end
      if (hold > 0) begin
        chk("en_hold", DecEnable, 1);
        chk("nc_stable", nC, exp_nc);
        chk("blk_stable", BlkIdx, b);
      end
      if (b == rst_blk) begin
        nReset = 1'b0;
        #1;
        chk("rst_en", DecEnable, 0);
        chk("rst_busy", MbBusy, 0);
        chk("rst_blk", BlkIdx, 0);
        chk("rst_nc", nC, 0);
        for (int i = 0; i < 4; i++) m_left[i] = 0;
        step();
        nReset = 1'b1;
        step();
        return;
      end
      TotalCoeff = 5'(tc_in[b]); BlockDone = 1'b1;
      step();
      BlockDone = 1'b0;
      m_cur[bx(b)][by(b)] = tc_in[b];
      if (by(b) == 3) begin m_lb[mbx*4 + bx(b)] = tc_in[b]; m_lbv[mbx*4 + bx(b)] = 1'b1; end
      if (bx(b) == 3) m_left[by(b)] = tc_in[b];
      chk("en_drop", DecEnable, 0);
      n = 1;
      if (b == spur_blk) begin
        TotalCoeff = 5'd31; BlockDone = 1'b1;
        step();
        BlockDone = 1'b0;
        n = 2;
      end
    end
    chk("mb_done_pulse", MbDone, 1);
    chk("busy_at_done", MbBusy, 1);
    step();
    chk("mb_done_clear", MbDone, 0);
    chk("busy_clear", MbBusy, 0);
  endtask

  initial begin
    int mbx;
    bit al, at;
    nReset = 1'b0; MbStart = 1'b0; BlockDone = 1'b0; TotalCoeff = 5'd0;
    MbX = 7'd0; MbAvailLeft = 1'b0; MbAvailTop = 1'b0; CodedBlockPattern = 4'hF;
    for (int i = 0; i < 4; i++) m_left[i] = 0;
    for (int i = 0; i < 480; i++) begin m_lb[i] = 0; m_lbv[i] = 1'b0; end
    repeat (2) step();
    chk("reset_busy", MbBusy, 0);
    chk("reset_en", DecEnable, 0);
    chk("reset_done", MbDone, 0);
    chk("reset_nc", nC, 0);
    chk("reset_blk", BlkIdx, 0);
    nReset = 1'b1;
    step();
    chk("idle_busy", MbBusy, 0);

    // First MB with no neighbours and all-zero coefficients.
    clear_tc();
    for (int i = 0; i < 16; i++) exp_fix[i] = 0;
    run_mb(0, 1'b0, 1'b0, -1, -1);

    // Right column {5:4, 7:8, 13:2, 15:6} feeds the next MB's left edge.
    clear_tc();
    tc_in[5] = 4; tc_in[7] = 8; tc_in[13] = 2; tc_in[15] = 6;
    run_mb(0, 1'b0, 1'b0, -1, 3);
    clear_tc();
    exp_fix[0] = 4;
    run_mb(1, 1'b1, 1'b0, -1, -1);

    // Left[0]=3 and top neighbour 6 -> blk0 nC = 5.
    clear_tc();
    tc_in[5] = 3; tc_in[10] = 6;
    run_mb(2, 1'b0, 1'b0, -1, -1);
    clear_tc();
    exp_fix[0] = 5;
    run_mb(2, 1'b1, 1'b1, -1, 7);

    // Within-MB neighbours.
    clear_tc();
    tc_in[0] = 7; tc_in[1] = 9; tc_in[2] = 5;
    exp_fix[1] = 7; exp_fix[3] = 7;
    run_mb(3, 1'b0, 1'b0, -1, -1);

    // Reset while running block 6, then a fresh MB from block 0.
    clear_tc();
    for (int i = 0; i < 16; i++) tc_in[i] = $urandom_range(1, 16);
    run_mb(4, 1'b1, 1'b0, 6, -1);
    clear_tc();
    exp_fix[0] = 0;
    run_mb(4, 1'b1, 1'b0, -1, -1);

    // Randomized macroblocks, including out-of-range TotalCoeff values.
    for (int k = 0; k < 12; k++) begin
      clear_tc();
      for (int i = 0; i < 16; i++)
        tc_in[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      mbx = $urandom_range(0, 7);
      al  = 1'($urandom_range(0, 1));
      at  = 1'($urandom_range(0, 1)) && m_lbv[mbx*4];
      run_mb(mbx, al, at, -1, $urandom_range(0, 14));
    end

`ifdef CAVLC_CBP_SKIP_EN
    begin
      int n;
      bit seen;
      CodedBlockPattern = 4'h0; MbX = 7'd5; MbAvailLeft = 1'b0; MbAvailTop = 1'b0; MbStart = 1'b1;
      step();
      MbStart = 1'b0;
      n = 1; seen = 1'b0;
      while (MbDone !== 1'b1 && n < 100) begin
        if (DecEnable === 1'b1) seen = 1'b1;
        step();
        n++;
      end
      chk("skip_cycles", n, 49);
      chk("skip_no_en", seen, 0);
      for (int i = 0; i < 4; i++) begin m_left[i] = 0; m_lb[20+i] = 0; m_lbv[20+i] = 1'b1; end
      CodedBlockPattern = 4'hF;
      step();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
